run_ctrl_seq: RTL and testbench



---
 rtl/run_ctrl_pkg.sv | 15 +
 rtl/run_ctrl_timer.sv | 24 ++
 rtl/run_ctrl_seq.sv | 124 ++++++++++++
 tb/tb_run_ctrl_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - run controller state encoding and domain release offsets
package run_ctrl_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Hold-counter value at which domain idx leaves reset.
    function automatic int unsigned rel_off(input int unsigned idx,
                                            input int unsigned hold,
                                            input int unsigned stagger);
        return hold + idx * stagger;
    endfunction

endpackage

// File: rtl/run_ctrl_timer.sv
// rtl/run_ctrl_timer.sv - saturating clear/enable up-counter with terminal-count compare
module run_ctrl_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic [CNT_W-1:0] count,
    output logic             tc_hit
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_hit = (count == tc);

endmodule

// File: rtl/run_ctrl_seq.sv
// rtl/run_ctrl_seq.sv - staggered-reset run controller with halt/timeout; watchdog under RUN_WATCHDOG_EN
module run_ctrl_seq
    import run_ctrl_pkg::*;
#(
    parameter int unsigned N_DOM       = 2,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned MAX_CYCLES  = 300,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_i,
    input  logic             restart,
    input  logic             kick,
    output logic [N_DOM-1:0] rst_out,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic             wdog_fired,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(rel_off(N_DOM - 1, HOLD_CYCLES, STAGGER) - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             tc_hit;
    logic [N_DOM-1:0] rel_now;
    logic             go_run;
    logic             restart_hit;
    logic             halt_hit;
    logic             to_hit;
    logic             wd_hit;
    logic             run_end;

    // One counter serves as the hold counter in HOLD and the run counter afterwards.
    run_ctrl_timer #(.CNT_W(CNT_W)) u_count (
        .clk    (clk),
        .rst    (rst),
        .clr    (restart_hit || go_run),
        .en     ((state == ST_HOLD) || ((state == ST_RUN) && !run_end)),
        .tc     (MAX_M1),
        .count  (count),
        .tc_hit (tc_hit)
    );

    always_comb begin
        rel_now = '0;
        for (int i = 0; i < N_DOM; i++) begin
            rel_now[i] = (count == CNT_W'(rel_off(i, HOLD_CYCLES, STAGGER) - 1));
        end
    end

    assign go_run      = (state == ST_HOLD) && (count == LAST_M1);
    assign restart_hit = restart && (state != ST_HOLD);
    assign halt_hit    = (state == ST_RUN) && halt_i;
    assign to_hit      = (state == ST_RUN) && (MAX_CYCLES != 0) && tc_hit;

`ifdef RUN_WATCHDOG_EN
    logic [CNT_W-1:0] wd_count_unused;
    logic             wd_tc;

    run_ctrl_timer #(.CNT_W(CNT_W)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state != ST_RUN) || kick),
        .en     (state == ST_RUN),
        .tc     (CNT_W'(WDOG_CYCLES - 1)),
        .count  (wd_count_unused),
        .tc_hit (wd_tc)
    );

    assign wd_hit = (state == ST_RUN) && !kick && wd_tc;
`else
    logic wdog_unused;
    assign wdog_unused = kick ^ (WDOG_CYCLES == 0);
    assign wd_hit      = 1'b0;
`endif

    assign run_end = halt_hit || to_hit || wd_hit;

    always_ff @(posedge clk) begin
        if (rst || restart_hit) begin
            state      <= ST_HOLD;
            rst_out    <= '1;
            running    <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            wdog_fired <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    rst_out <= rst_out & ~rel_now;
                    if (go_run) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_end) begin
                        state      <= ST_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        timed_out  <= to_hit && !halt_hit;
                        wdog_fired <= wd_hit && !halt_hit && !to_hit;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    // The shared counter holds the hold count during HOLD; report only run cycles.
    assign cycle_count = (state == ST_HOLD) ? '0 : count;

endmodule

// File: tb/tb_run_ctrl_seq.sv
// tb/tb_run_ctrl_seq.sv - self-checking bench for run_ctrl_seq (default parameters)
module tb_run_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i;
    logic        restart;
    logic        kick;
    logic [1:0]  rst_out;
    logic        running;
    logic        done;
    logic        timed_out;
    logic        wdog_fired;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        halt;
        logic        rstrt;
        logic [1:0]  e_rst_out;
        logic        e_running;
        logic        e_done;
        logic [31:0] e_cc;
    } vec_t;

    vec_t tbl [8];

    run_ctrl_seq dut (
        .clk         (clk),
        .rst         (rst),
        .halt_i      (halt_i),
        .restart     (restart),
        .kick        (kick),
        .rst_out     (rst_out),
        .running     (running),
        .done        (done),
        .timed_out   (timed_out),
        .wdog_fired  (wdog_fired),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end, required finish before 500000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_ro, input logic e_run,
                           input logic e_done, input logic e_to, input logic e_wd,
                           input logic [31:0] e_cc);
        chk({tag, "_rst_out"},     rst_out,     e_ro);
        chk({tag, "_running"},     running,     e_run);
        chk({tag, "_done"},        done,        e_done);
        chk({tag, "_timed_out"},   timed_out,   e_to);
        chk({tag, "_wdog_fired"},  wdog_fired,  e_wd);
        chk({tag, "_cycle_count"}, cycle_count, e_cc);
    endtask

    // Release sequence from the first cycle after reset/restart (count 0).
    task automatic run_table(input string tag);
        for (int k = 0; k < 8; k++) begin
            halt_i  = tbl[k].halt;
            restart = tbl[k].rstrt;
            chk($sformatf("%s_c%0d_rst_out", tag, k), rst_out,     tbl[k].e_rst_out);
            chk($sformatf("%s_c%0d_running", tag, k), running,     tbl[k].e_running);
            chk($sformatf("%s_c%0d_done", tag, k),    done,        tbl[k].e_done);
            chk($sformatf("%s_c%0d_cc", tag, k),      cycle_count, tbl[k].e_cc);
            step();
        end
        halt_i  = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        // halt and restart pulses inside HOLD must be ignored
        tbl[0] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0};
        tbl[4] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'd0};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'd1};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'd2};

        rst     = 1'b1;
        halt_i  = 1'b0;
        restart = 1'b0;
        kick    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        run_table("pwr");

        steps(37);
        chk_all("pre_halt", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd40);
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        chk_all("halt40", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd40);
        halt_i = 1'b1;
        steps(2);
        halt_i = 1'b0;
        steps(2);
        chk_all("halt40_sticky", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd40);

        restart = 1'b1;
        step();
        restart = 1'b0;
        chk_all("restart_done", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_table("rs1");

        steps(7);
        chk("pre_restart_cc", cycle_count, 32'd10);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk_all("restart_run", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_table("rs2");

        steps(296);
        chk_all("pre_timeout", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd299);
        step();
        chk_all("timeout", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'd299);
        steps(5);
        chk_all("timeout_frozen", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'd299);

        restart = 1'b1;
        step();
        restart = 1'b0;
        run_table("rs3");
        steps(17);
        chk("pre_rst_cc", cycle_count, 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_mid_run", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_table("rst2");

        steps(296);
        chk("pre_tie_cc", cycle_count, 32'd299);
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        chk_all("halt_vs_timeout", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd299);

`ifdef RUN_WATCHDOG_EN
        restart = 1'b1;
        step();
        restart = 1'b0;
        run_table("wd");
        for (int r = 0; r < 3; r++) begin
            kick = 1'b1;
            step();
            kick = 1'b0;
            steps(49);
            chk($sformatf("wd_nofire_%0d", r), running, 1'b1);
        end
        chk("wd_last_kick_cc", cycle_count, 32'd153);
        kick = 1'b1;
        step();
        kick = 1'b0;
        steps(63);
        chk_all("wd_pre_fire", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd217);
        step();
        chk_all("wd_fire", 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'd217);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
